// File: rtl/seller_dispense_if.sv
// Seller-to-dispenser link: sale/change inputs, hopper sensor, motor drives and status.
// Optional statistic outputs are present when SELLER_DISP_STAT_EN is defined.
interface seller_dispense_if;
  logic       out1;
  logic [1:0] out2;
  logic       coin_sns;
  logic       item_motor;
  logic       coin_motor;
  logic       busy;
  logic       ovf;
  logic       fault;
`ifdef SELLER_DISP_STAT_EN
  logic [15:0] sale_cnt;
  logic [15:0] coin_cnt;

  modport master (
    output out1, out2, coin_sns,
    input  item_motor, coin_motor, busy, ovf, fault,
    input  sale_cnt, coin_cnt
  );
  modport slave (
    input  out1, out2, coin_sns,
    output item_motor, coin_motor, busy, ovf, fault,
    output sale_cnt, coin_cnt
  );
`else
  modport master (
    output out1, out2, coin_sns,
    input  item_motor, coin_motor, busy, ovf, fault
  );
  modport slave (
    input  out1, out2, coin_sns,
    output item_motor, coin_motor, busy, ovf, fault
  );
`endif
endinterface

// File: rtl/seller_dispense.sv
// Sale job queue driving item-release motor and coin hopper with timeout.
// SELLER_DISP_STAT_EN adds saturating sale_cnt/coin_cnt statistic outputs.
module seller_dispense #(
  parameter int ITEM_CYC = 4,
  parameter int COIN_TMO = 16,
  parameter int GAP_CYC  = 2
) (
  input logic clk,
  input logic rst,
  seller_dispense_if.slave bus
);
  localparam int M1   = (ITEM_CYC > COIN_TMO) ? ITEM_CYC : COIN_TMO;
  localparam int MAXC = (M1 > GAP_CYC) ? M1 : GAP_CYC;
  localparam int TW   = $clog2(MAXC + 1);

  localparam logic [TW-1:0] ITEM_LAST = TW'(ITEM_CYC - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYC - 1);
  localparam logic [TW-1:0] COIN_LAST = TW'(COIN_TMO - 1);

  typedef enum logic [2:0] {
    IDLE, ITEM, GAP, COIN, HALT
  } state_t;

  state_t        state;
  logic [TW-1:0] tmr;
  logic [1:0]    coin_left;

  logic [1:0] q_mem [2];
  logic       q_wr;
  logic       q_rd;
  logic [1:0] q_cnt;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;

  assign full  = (q_cnt == 2'd2);
  assign empty = (q_cnt == 2'd0);
  assign push  = bus.out1 && !full;
  assign pop   = (state == IDLE) && !empty;

  assign bus.busy = ((state != IDLE) && (state != HALT)) || !empty;

  // Two-entry change-code FIFO; a sale that finds it full is dropped and flagged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_mem[0] <= '0;
      q_mem[1] <= '0;
      q_wr     <= 1'b0;
      q_rd     <= 1'b0;
      q_cnt    <= '0;
      bus.ovf  <= 1'b0;
    end else begin
      if (push) begin
        q_mem[q_wr] <= bus.out2;
        q_wr        <= ~q_wr;
      end
      if (pop) q_rd <= ~q_rd;
      if (bus.out1 && full) bus.ovf <= 1'b1;
      unique case ({push, pop})
        2'b10:   q_cnt <= q_cnt + 2'd1;
        2'b01:   q_cnt <= q_cnt - 2'd1;
        default: ;
      endcase
    end
  end

  // Job sequencer: item release, then gap/coin cycles until change is paid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      tmr            <= '0;
      coin_left      <= '0;
      bus.item_motor <= 1'b0;
      bus.coin_motor <= 1'b0;
      bus.fault      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            coin_left      <= q_mem[q_rd];
            tmr            <= '0;
            bus.item_motor <= 1'b1;
            state          <= ITEM;
          end
        end
        ITEM: begin
          if (tmr == ITEM_LAST) begin
            tmr            <= '0;
            bus.item_motor <= 1'b0;
            state          <= (coin_left == 2'd0) ? IDLE : GAP;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        GAP: begin
          if (tmr == GAP_LAST) begin
            tmr            <= '0;
            bus.coin_motor <= 1'b1;
            state          <= COIN;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        COIN: begin
          if (bus.coin_sns) begin
            tmr            <= '0;
            coin_left      <= coin_left - 2'd1;
            bus.coin_motor <= 1'b0;
            state          <= (coin_left == 2'd1) ? IDLE : GAP;
          end else if (tmr == COIN_LAST) begin
            coin_left      <= '0;
            bus.coin_motor <= 1'b0;
            bus.fault      <= 1'b1;
            state          <= HALT;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        HALT:    ;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SELLER_DISP_STAT_EN
  logic coin_done;
  logic sale_done;

  assign coin_done = (state == COIN) && bus.coin_sns;
  assign sale_done = ((state == ITEM) && (tmr == ITEM_LAST) &&
                      (coin_left == 2'd0)) ||
                     (coin_done && (coin_left == 2'd1));

  // Saturating counts of completed sales and confirmed coins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.sale_cnt <= '0;
      bus.coin_cnt <= '0;
    end else begin
      if (sale_done && (bus.sale_cnt != 16'hFFFF))
        bus.sale_cnt <= bus.sale_cnt + 16'd1;
      if (coin_done && (bus.coin_cnt != 16'hFFFF))
        bus.coin_cnt <= bus.coin_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_seller_dispense.sv
// Bench for seller_dispense: vector table, directed corner sequences,
// and randomized traffic against a deadline-based job model.
`timescale 1ns/1ps
module tb_seller_dispense;
  localparam int ITEM_CYC = 4;
  localparam int COIN_TMO = 16;
  localparam int GAP_CYC  = 2;

  localparam int MI = 0;
  localparam int MT = 1;
  localparam int MG = 2;
  localparam int MC = 3;
  localparam int MH = 4;

  logic clk = 1'b1;
  logic rst = 1'b0;

  int checks   = 0;
  int failures = 0;

  seller_dispense_if bus ();

  seller_dispense #(
    .ITEM_CYC(ITEM_CYC),
    .COIN_TMO(COIN_TMO),
    .GAP_CYC (GAP_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int m_q[$];
  int m_mode;
  int m_end;
  int m_coins;
  int m_cstart;
  int m_ovf;
  int m_fault;
  int m_sale;
  int m_coin;
  int n = 0;

  typedef struct {
    logic       i1;
    logic [1:0] i2;
    logic       s;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl [18];

  task automatic model_reset();
    m_q.delete();
    m_mode  = MI;
    m_end   = 0;
    m_coins = 0;
    m_cstart = 0;
    m_ovf   = 0;
    m_fault = 0;
    m_sale  = 0;
    m_coin  = 0;
  endtask

  task automatic sale_inc();
    if (m_sale < 65535) m_sale++;
  endtask

  task automatic model_step(input logic i1, input logic [1:0] i2,
                            input logic s);
    int sz;
    sz = m_q.size();
    case (m_mode)
      MI: if (sz > 0) begin
        m_coins = m_q.pop_front();
        m_mode  = MT;
        m_end   = n + ITEM_CYC;
      end
      MT: if (n == m_end) begin
        if (m_coins == 0) begin
          m_mode = MI;
          sale_inc();
        end else begin
          m_mode = MG;
          m_end  = n + GAP_CYC;
        end
      end
      MG: if (n == m_end) begin
        m_mode   = MC;
        m_cstart = n;
        m_end    = n + COIN_TMO;
      end
      MC: begin
        if (s) begin
          if (m_coin < 65535) m_coin++;
          m_coins--;
          if (m_coins == 0) begin
            m_mode = MI;
            sale_inc();
          end else begin
            m_mode = MG;
            m_end  = n + GAP_CYC;
          end
        end else if (n == m_end) begin
          m_fault = 1;
          m_mode  = MH;
        end
      end
      default: ;
    endcase
    if (i1) begin
      if (sz < 2) m_q.push_back(int'(i2));
      else m_ovf = 1;
    end
    n++;
  endtask

  function automatic logic [4:0] dut_o();
    return {bus.item_motor, bus.coin_motor, bus.busy, bus.ovf, bus.fault};
  endfunction

  function automatic logic [4:0] mdl_o();
    logic act;
    act = (m_mode == MT) || (m_mode == MG) || (m_mode == MC);
    return {m_mode == MT, m_mode == MC, act || (m_q.size() > 0),
            m_ovf != 0, m_fault != 0};
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h want=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_model(input string nm);
    chk(nm, int'(dut_o()), int'(mdl_o()));
`ifdef SELLER_DISP_STAT_EN
    chk({nm, "_sale"}, int'(bus.sale_cnt), m_sale);
    chk({nm, "_coin"}, int'(bus.coin_cnt), m_coin);
`endif
  endtask

  task automatic cycle(input logic i1, input logic [1:0] i2,
                       input logic s, input bit c);
    bus.out1     = i1;
    bus.out2     = i2;
    bus.coin_sns = s;
    model_step(i1, i2, s);
    @(negedge clk);
    if (c) chk_model("cyc");
  endtask

  task automatic do_reset();
    bus.out1     = 1'b0;
    bus.out2     = 2'd0;
    bus.coin_sns = 1'b0;
    #2 rst = 1'b0;
    #1 chk("rst_async", int'(dut_o()), 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    int bursts;
    int low;
    int items;
    logic prev;
    logic prev_i;
    bus.out1     = 1'b0;
    bus.out2     = 2'd0;
    bus.coin_sns = 1'b0;
    model_reset();

    tbl[0]  = '{1'b1, 2'd0, 1'b0, 5'b00100};
    tbl[1]  = '{1'b0, 2'd0, 1'b0, 5'b10100};
    tbl[2]  = '{1'b0, 2'd0, 1'b0, 5'b10100};
    tbl[3]  = '{1'b0, 2'd0, 1'b0, 5'b10100};
    tbl[4]  = '{1'b0, 2'd0, 1'b0, 5'b10100};
    tbl[5]  = '{1'b0, 2'd0, 1'b0, 5'b00000};
    tbl[6]  = '{1'b1, 2'd1, 1'b0, 5'b00100};
    tbl[7]  = '{1'b0, 2'd0, 1'b0, 5'b10100};
    tbl[8]  = '{1'b0, 2'd0, 1'b0, 5'b10100};
    tbl[9]  = '{1'b0, 2'd0, 1'b0, 5'b10100};
    tbl[10] = '{1'b0, 2'd0, 1'b0, 5'b10100};
    tbl[11] = '{1'b0, 2'd0, 1'b0, 5'b00100};
    tbl[12] = '{1'b0, 2'd0, 1'b0, 5'b00100};
    tbl[13] = '{1'b0, 2'd0, 1'b0, 5'b01100};
    tbl[14] = '{1'b0, 2'd0, 1'b0, 5'b01100};
    tbl[15] = '{1'b0, 2'd0, 1'b1, 5'b00000};
    tbl[16] = '{1'b0, 2'd0, 1'b1, 5'b00000};
    tbl[17] = '{1'b0, 2'd0, 1'b0, 5'b00000};

    // T1: reset held from t=0, released on the 5 ns falling edge
    #1 chk("t1_in_rst", int'(dut_o()), 0);
    @(negedge clk);
    rst = 1'b1;
    chk("t1_release", int'(dut_o()), 0);
    chk_model("t1_model");

    // T2 plus a one-coin sale, from the vector table
    for (int i = 0; i < 18; i++) begin
      cycle(tbl[i].i1, tbl[i].i2, tbl[i].s, 1'b0);
      chk($sformatf("tbl%0d", i), int'(dut_o()), int'(tbl[i].exp));
      chk_model("tbl_model");
    end

    // T3: three coins, sensor answers 3 cycles into each COIN
    do_reset();
    cycle(1'b1, 2'd3, 1'b0, 1'b1);
    bursts = 0;
    low    = 0;
    prev   = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (m_mode == MI && m_q.size() == 0) break;
      cycle(1'b0, 2'd0, (m_mode == MC) && (n == m_cstart + 3), 1'b1);
      if (bus.coin_motor && !prev) begin
        bursts++;
        if (bursts > 1) chk("t3_gap", low, GAP_CYC);
      end
      low  = bus.coin_motor ? 0 : low + 1;
      prev = bus.coin_motor;
    end
    chk("t3_bursts", bursts, 3);
    chk("t3_idle", int'(dut_o()), 0);
`ifdef SELLER_DISP_STAT_EN
    chk("t6_sale_cnt", int'(bus.sale_cnt), 1);
    chk("t6_coin_cnt", int'(bus.coin_cnt), 3);
`endif

    // T4: three back-to-back sales during a job, third dropped
    do_reset();
    cycle(1'b1, 2'd1, 1'b0, 1'b1);
    cycle(1'b0, 2'd0, 1'b0, 1'b1);
    cycle(1'b1, 2'd2, 1'b0, 1'b1);
    cycle(1'b1, 2'd0, 1'b0, 1'b1);
    cycle(1'b1, 2'd3, 1'b0, 1'b1);
    chk("t4_ovf", int'(bus.ovf), 1);
    items  = 0;
    prev_i = bus.item_motor;
    for (int k = 0; k < 150; k++) begin
      if (m_mode == MI && m_q.size() == 0) break;
      cycle(1'b0, 2'd0, (m_mode == MC) && (n == m_cstart + 1), 1'b1);
      if (bus.item_motor && !prev_i) items++;
      prev_i = bus.item_motor;
    end
    chk("t4_items", items, 2);
    chk("t4_end", int'(dut_o()), 5'b00010);

    // T5: hopper never answers -> fault and HALT until reset
    do_reset();
    cycle(1'b1, 2'd2, 1'b0, 1'b1);
    for (int k = 0; k < 60; k++) begin
      if (m_mode == MH) break;
      cycle(1'b0, 2'd0, 1'b0, 1'b1);
    end
    chk("t5_halt", int'(dut_o()), 5'b00001);
    for (int k = 0; k < 5; k++) cycle(1'b0, 2'd0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) cycle(1'b1, 2'd1, 1'b0, 1'b1);
    chk("t5_q_ovf", int'(dut_o()), 5'b00111);
    do_reset();
    chk_model("t5_after_rst");

    // T6: reset during ITEM drops the motor asynchronously
    cycle(1'b1, 2'd0, 1'b0, 1'b1);
    cycle(1'b0, 2'd0, 1'b0, 1'b1);
    cycle(1'b0, 2'd0, 1'b0, 1'b1);
    chk("t6_item_on", int'(bus.item_motor), 1);
    do_reset();
    chk_model("t6_after_rst");

    // Randomized traffic with occasional resets
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)),
              $urandom_range(0, 3) == 0, 1'b1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
